// File: rtl/conway_pkg.sv
// Shared constants, FSM states and address-width helper for the Conway row feeder.
// Defining CONWAY_TORUS_EN wraps the grid edges so the board becomes a torus.
package conway_pkg;

    localparam int WORD_LEN = 20;
    localparam int WIN_LEN  = 22;

`ifdef CONWAY_TORUS_EN
    localparam bit TORUS_EN = 1'b1;
`else
    localparam bit TORUS_EN = 1'b0;
`endif

    // Column indices inside the 3x3 word register array.
    localparam logic [1:0] COL_LEFT   = 2'd0;
    localparam logic [1:0] COL_CENTRE = 2'd1;
    localparam logic [1:0] COL_RIGHT  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_FETCH,
        ST_EMIT,
        ST_DONE
    } state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conway_row_feeder_if.sv
// Bundle of the feeder's control, read, window and write signals.
// master = the feeder itself, slave = RAMs / cell array / controller around it.
interface conway_row_feeder_if #(
    parameter int GRID_ROWS  = 480,
    parameter int GRID_WORDS = 32
);
    import conway_pkg::*;

    localparam int RW = addr_w(GRID_ROWS);
    localparam int WW = addr_w(GRID_WORDS);

    logic                start;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [RW-1:0]       rd_row;
    logic [WW-1:0]       rd_word;
    logic [WORD_LEN-1:0] rd_data;
    logic [WIN_LEN-1:0]  top_row;
    logic [WIN_LEN-1:0]  middle_row;
    logic [WIN_LEN-1:0]  bottom_row;
    logic                win_valid;
    logic [WORD_LEN-1:0] result;
    logic                wr_en;
    logic [RW-1:0]       wr_row;
    logic [WW-1:0]       wr_word;
    logic [WORD_LEN-1:0] wr_data;
    logic                wr_ready;

    modport master (
        input  start, rd_data, result, wr_ready,
        output busy, done, rd_en, rd_row, rd_word,
               top_row, middle_row, bottom_row, win_valid,
               wr_en, wr_row, wr_word, wr_data
    );

    modport slave (
        output start, rd_data, result, wr_ready,
        input  busy, done, rd_en, rd_row, rd_word,
               top_row, middle_row, bottom_row, win_valid,
               wr_en, wr_row, wr_word, wr_data
    );

endinterface

// File: rtl/conway_col_fetch.sv
// Four-cycle column loader: reads rows r-1, r, r+1 of one word, then one capture cycle.
// Edge rows are zero-filled, or wrapped when CONWAY_TORUS_EN is defined.
module conway_col_fetch
    import conway_pkg::*;
#(
    parameter int GRID_ROWS  = 480,
    parameter int GRID_WORDS = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             go_i,
    input  logic                             zero_i,
    input  logic [addr_w(GRID_ROWS)-1:0]     row_i,
    input  logic [addr_w(GRID_WORDS)-1:0]    word_i,
    input  logic [WORD_LEN-1:0]              rd_data_i,
    output logic                             rd_en_o,
    output logic [addr_w(GRID_ROWS)-1:0]     rd_row_o,
    output logic [addr_w(GRID_WORDS)-1:0]    rd_word_o,
    output logic                             cap_valid_o,
    output logic [1:0]                       cap_slot_o,
    output logic [WORD_LEN-1:0]              cap_data_o,
    output logic                             last_o
);

    localparam int RW = addr_w(GRID_ROWS);

    logic [1:0]    phase_q, phase_d;
    logic          rd_pend_q;
    int            tgt_row;
    logic          in_grid;
    logic [RW-1:0] row_addr;

    // Phase 0/1/2 addresses rows r-1/r/r+1; phase 3 only captures the last word.
    always_comb begin
        tgt_row  = int'(row_i) + int'(phase_q) - 1;
        in_grid  = (tgt_row >= 0) && (tgt_row < GRID_ROWS);
        row_addr = '0;
        if (in_grid) begin
            row_addr = tgt_row[RW-1:0];
        end
        if (TORUS_EN) begin
            in_grid = 1'b1;
            if (tgt_row < 0) begin
                row_addr = RW'(GRID_ROWS - 1);
            end else if (tgt_row >= GRID_ROWS) begin
                row_addr = '0;
            end
        end
    end

    assign rd_en_o     = go_i && (phase_q != 2'd3) && in_grid && !zero_i;
    assign rd_row_o    = rd_en_o ? row_addr : '0;
    assign rd_word_o   = rd_en_o ? word_i : '0;
    assign last_o      = go_i && (phase_q == 2'd3);
    assign cap_valid_o = go_i && (phase_q != 2'd0);
    assign cap_slot_o  = phase_q - 2'd1;
    // A slot with no read behind it loads a dead word.
    assign cap_data_o  = rd_pend_q ? rd_data_i : '0;

    assign phase_d = go_i ? phase_q + 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 2'd0;
            rd_pend_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            rd_pend_q <= rd_en_o;
        end
    end

endmodule

// File: rtl/conway_row_feeder.sv
// Streams 3x3 word neighbourhoods of the current generation to a cell array and writes back results.
// CONWAY_TORUS_EN selects wrap-around edges instead of dead borders.
module conway_row_feeder
    import conway_pkg::*;
#(
    parameter int GRID_ROWS  = 480,
    parameter int GRID_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    conway_row_feeder_if.master  bus
);

    localparam int RW = addr_w(GRID_ROWS);
    localparam int WW = addr_w(GRID_WORDS);
    localparam logic [RW-1:0] LAST_ROW  = RW'(GRID_ROWS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(GRID_WORDS - 1);

    state_e              state_q;
    logic [RW-1:0]       row_q;
    logic [WW-1:0]       word_q;
    logic                prime_left_q;
    logic [WORD_LEN-1:0] col_q [3][3];   // [column][row slot]

    logic                fetch_go;
    logic                fetch_zero;
    logic [WW-1:0]       fetch_word;
    logic [1:0]          fetch_col;
    logic                fetch_last;
    logic                cap_valid;
    logic [1:0]          cap_slot;
    logic [WORD_LEN-1:0] cap_data;
    logic [WIN_LEN-1:0]  win_rows [3];

    // Which word is being loaded and into which column, decoded from the FSM.
    always_comb begin
        fetch_go   = 1'b0;
        fetch_zero = 1'b0;
        fetch_word = '0;
        fetch_col  = COL_CENTRE;
        unique case (state_q)
            ST_PRIME: begin
                fetch_go = 1'b1;
                if (prime_left_q) begin
                    fetch_col  = COL_LEFT;
                    fetch_word = LAST_WORD;
                end
            end
            ST_FETCH: begin
                fetch_go  = 1'b1;
                fetch_col = COL_RIGHT;
                if (word_q == LAST_WORD) begin
                    fetch_zero = !TORUS_EN;
                end else begin
                    fetch_word = word_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    conway_col_fetch #(
        .GRID_ROWS  (GRID_ROWS),
        .GRID_WORDS (GRID_WORDS)
    ) u_col_fetch (
        .clk         (clk),
        .reset_n     (reset_n),
        .go_i        (fetch_go),
        .zero_i      (fetch_zero),
        .row_i       (row_q),
        .word_i      (fetch_word),
        .rd_data_i   (bus.rd_data),
        .rd_en_o     (bus.rd_en),
        .rd_row_o    (bus.rd_row),
        .rd_word_o   (bus.rd_word),
        .cap_valid_o (cap_valid),
        .cap_slot_o  (cap_slot),
        .cap_data_o  (cap_data),
        .last_o      (fetch_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            word_q       <= '0;
            prime_left_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    col_q[c][r] <= '0;
                end
            end
        end else begin
            if (cap_valid) begin
                col_q[fetch_col][cap_slot] <= cap_data;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q      <= ST_PRIME;
                        row_q        <= '0;
                        word_q       <= '0;
                        prime_left_q <= TORUS_EN;
                        for (int c = 0; c < 3; c++) begin
                            for (int r = 0; r < 3; r++) begin
                                col_q[c][r] <= '0;
                            end
                        end
                    end
                end
                ST_PRIME: begin
                    if (fetch_last) begin
                        if (prime_left_q) begin
                            prime_left_q <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_last) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.wr_ready) begin
                        for (int r = 0; r < 3; r++) begin
                            col_q[COL_LEFT][r]   <= col_q[COL_CENTRE][r];
                            col_q[COL_CENTRE][r] <= col_q[COL_RIGHT][r];
                        end
                        if (word_q == LAST_WORD) begin
                            // Row finished: the next row starts with a dead left border.
                            word_q <= '0;
                            for (int r = 0; r < 3; r++) begin
                                col_q[COL_LEFT][r] <= '0;
                            end
                            if (row_q == LAST_ROW) begin
                                state_q <= ST_DONE;
                            end else begin
                                row_q        <= row_q + 1'b1;
                                prime_left_q <= TORUS_EN;
                                state_q      <= ST_PRIME;
                            end
                        end else begin
                            word_q  <= word_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Window row = {right bit 0, centre word, left bit 19}; slot 0 is row r-1.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_win
        assign win_rows[gi] = {col_q[COL_RIGHT][gi][0],
                               col_q[COL_CENTRE][gi],
                               col_q[COL_LEFT][gi][WORD_LEN-1]};
    end

    assign bus.top_row    = win_rows[0];
    assign bus.middle_row = win_rows[1];
    assign bus.bottom_row = win_rows[2];
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.win_valid  = (state_q == ST_EMIT);
    assign bus.wr_en      = (state_q == ST_EMIT) && bus.wr_ready;
    assign bus.wr_row     = row_q;
    assign bus.wr_word    = word_q;
    assign bus.wr_data    = bus.result;

endmodule

// File: tb/tb_conway_row_feeder.sv
// Directed bench for conway_row_feeder on a 4x40 grid with RAM and cell-array models.
// Build with CONWAY_TORUS_EN defined to exercise the wrap-around scenario.
module tb_conway_row_feeder;
    import conway_pkg::*;

    localparam int R = 4;
    localparam int W = 2;
`ifdef CONWAY_TORUS_EN
    localparam int RD_PER_PASS   = 48;
    localparam int BUSY_PER_PASS = 73;
`else
    localparam int RD_PER_PASS   = 20;
    localparam int BUSY_PER_PASS = 57;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr_req = 1'b0;
    always #5 clk = ~clk;

    conway_row_feeder_if #(.GRID_ROWS(R), .GRID_WORDS(W)) ifc();

    conway_row_feeder #(.GRID_ROWS(R), .GRID_WORDS(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    logic [19:0] cur_mem [R][W];
    logic [19:0] nxt_mem [R][W];
    logic [19:0] exp_mem [R][W];
    int errors = 0;
    int checks = 0;
    int wr_cnt, rd_cnt, busy_cnt, done_cnt, bad_top;
    logic [1:0] first_row;
    logic       first_word;

    // Game of Life rule applied to the 20 centre cells of the window.
    function automatic logic [19:0] life(input logic [21:0] t, input logic [21:0] m, input logic [21:0] b);
        logic [19:0] o;
        int n;
        o = '0;
        for (int i = 0; i < 20; i++) begin
            n = int'(t[i]) + int'(t[i+1]) + int'(t[i+2]) + int'(m[i]) + int'(m[i+2])
              + int'(b[i]) + int'(b[i+1]) + int'(b[i+2]);
            o[i] = (n == 3) || (m[i+1] && (n == 2));
        end
        return o;
    endfunction

    assign ifc.result = life(ifc.top_row, ifc.middle_row, ifc.bottom_row);

    always @(posedge clk) begin
        ifc.rd_data <= ifc.rd_en ? cur_mem[ifc.rd_row][ifc.rd_word] : 20'hABCDE;
        if (clr_req) begin
            wr_cnt  <= 0;
            nxt_mem <= '{default: 20'h0};
        end else if (ifc.wr_en) begin
            nxt_mem[ifc.wr_row][ifc.wr_word] <= ifc.wr_data;
            wr_cnt <= wr_cnt + 1;
            if (wr_cnt == 0) begin
                first_row  <= ifc.wr_row;
                first_word <= ifc.wr_word;
            end
        end
    end

    always @(negedge clk) begin
        if (clr_req) begin
            rd_cnt <= 0; busy_cnt <= 0; done_cnt <= 0; bad_top <= 0;
        end else begin
            if (ifc.rd_en) rd_cnt <= rd_cnt + 1;
            if (ifc.busy)  busy_cnt <= busy_cnt + 1;
            if (ifc.done)  done_cnt <= done_cnt + 1;
            if (ifc.win_valid && ifc.wr_row == 2'd0 && ifc.top_row != 22'h0) bad_top <= bad_top + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        clr_req = 1'b1;
        @(posedge clk); #2;
        clr_req = 1'b0;
    endtask

    task automatic start_pass();
        ifc.start = 1'b1;
        @(posedge clk); #2;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!ifc.done && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_done_seen"}, ifc.done, 1'b1);
        @(posedge clk); #2;
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < R; r++)
            for (int w = 0; w < W; w++)
                check($sformatf("%s_r%0dw%0d", tag, r, w), nxt_mem[r][w], exp_mem[r][w]);
    endtask

    task automatic load_blinker();
        cur_mem = '{default: 20'h0};
        cur_mem[1][0] = 20'h80000;
        cur_mem[1][1] = 20'h00003;
        exp_mem = '{default: 20'h0};
        exp_mem[0][1] = 20'h00001;
        exp_mem[1][1] = 20'h00001;
        exp_mem[2][1] = 20'h00001;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] snap_t, snap_m, snap_b;
        logic [1:0]  snap_row;
        logic        snap_word;
        int hold_bad;
        int n;

        ifc.start = 1'b0;
        ifc.wr_ready = 1'b1;
        cur_mem = '{default: 20'h0};
        exp_mem = '{default: 20'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_done", ifc.done, 1'b0);
        check("rst_rd_en", ifc.rd_en, 1'b0);
        check("rst_rd_row", ifc.rd_row, 2'd0);
        check("rst_win_valid", ifc.win_valid, 1'b0);
        check("rst_wr_en", ifc.wr_en, 1'b0);
        check("rst_wr_addr", {ifc.wr_row, ifc.wr_word}, 3'd0);
        check("rst_top", ifc.top_row, 22'h0);
        check("rst_mid", ifc.middle_row, 22'h0);
        check("rst_bot", ifc.bottom_row, 22'h0);
        reset_n = 1'b1;
        clear_stats();
        repeat (5) @(posedge clk);
        #2;
        check("idle_no_rd", rd_cnt, 0);

        // Blinker straddling the word boundary
        load_blinker();
        clear_stats();
        start_pass();
        wait_done("blink", 300);
        check_mem("blink");
        check("blink_writes", wr_cnt, 8);
        check("blink_done_pulses", done_cnt, 1);
        check("blink_busy_cycles", busy_cnt, BUSY_PER_PASS);
        check("blink_reads", rd_cnt, RD_PER_PASS);

        // Still-life block in the top-left corner
        cur_mem = '{default: 20'h0};
        cur_mem[0][0] = 20'h00003;
        cur_mem[1][0] = 20'h00003;
        exp_mem = cur_mem;
        clear_stats();
        start_pass();
        wait_done("block", 300);
        check_mem("block");
        check("block_row0_top_zero", bad_top, 0);
        check("block_reads", rd_cnt, RD_PER_PASS);

        // Back-pressure on the first write
        load_blinker();
        clear_stats();
        ifc.wr_ready = 1'b0;
        start_pass();
        n = 0;
        while (!ifc.win_valid && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_emit_seen", ifc.win_valid, 1'b1);
        snap_t = ifc.top_row; snap_m = ifc.middle_row; snap_b = ifc.bottom_row;
        snap_row = ifc.wr_row; snap_word = ifc.wr_word;
        check("bp_first_addr", {snap_row, snap_word}, 3'd0);
        check("bp_first_top", snap_t, 22'h0);
        check("bp_first_bottom", snap_b, 22'h300000);
        hold_bad = 0;
        repeat (10) begin
            @(posedge clk); #2;
            if (ifc.top_row !== snap_t || ifc.middle_row !== snap_m || ifc.bottom_row !== snap_b ||
                ifc.wr_row !== snap_row || ifc.wr_word !== snap_word ||
                ifc.win_valid !== 1'b1 || ifc.wr_en !== 1'b0)
                hold_bad++;
        end
        check("bp_hold_cycles_bad", hold_bad, 0);
        check("bp_no_writes", wr_cnt, 0);
        ifc.wr_ready = 1'b1;
        #1;
        check("bp_wr_en_on_ready", ifc.wr_en, 1'b1);
        @(posedge clk); #2;
        check("bp_write_count", wr_cnt, 1);
        wait_done("bp", 300);
        check_mem("bp");
        check("bp_writes", wr_cnt, 8);

        // Reset mid-row 2, then ignored start while busy
        load_blinker();
        clear_stats();
        start_pass();
        n = 0;
        while (!(ifc.win_valid && ifc.wr_row == 2'd2) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("rr_row2_reached", ifc.wr_row, 2'd2);
        reset_n = 1'b0;
        #1;
        check("rr_busy", ifc.busy, 1'b0);
        check("rr_win_valid", ifc.win_valid, 1'b0);
        check("rr_wr_en", ifc.wr_en, 1'b0);
        check("rr_rd_en", ifc.rd_en, 1'b0);
        check("rr_wr_addr", {ifc.wr_row, ifc.wr_word}, 3'd0);
        check("rr_mid", ifc.middle_row, 22'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        check("rr_idle_no_rd", rd_cnt, 0);
        start_pass();
        repeat (3) @(posedge clk);
        #2;
        start_pass();
        wait_done("rr", 300);
        check("rr_first_write", {first_row, first_word}, 3'd0);
        check("rr_writes", wr_cnt, 8);
        check("rr_busy_cycles", busy_cnt, BUSY_PER_PASS);
        check("rr_done_pulses", done_cnt, 1);
        check_mem("rr");

`ifdef CONWAY_TORUS_EN
        // Blinker across the left/right seam on row 0
        cur_mem = '{default: 20'h0};
        cur_mem[0][0] = 20'h00003;
        cur_mem[0][1] = 20'h80000;
        exp_mem = '{default: 20'h0};
        exp_mem[3][0] = 20'h00001;
        exp_mem[0][0] = 20'h00001;
        exp_mem[1][0] = 20'h00001;
        clear_stats();
        start_pass();
        wait_done("torus", 300);
        check_mem("torus");
        check("torus_writes", wr_cnt, 8);
        check("torus_reads", rd_cnt, RD_PER_PASS);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conway_row_feeder.md
CONWAY_ROW_FEEDER -- requirements
Module: conway_row_feeder

Interface
REQ-001 SHALL have parameter GRID_ROWS, default 480: number of grid rows.
REQ-002 SHALL have parameter GRID_WORDS, default 32: 20-cell words per row (grid width = 20*GRID_WORDS).
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins one generation pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  read strobe to the current-generation RAM.
- rd_row  out  clog2(GRID_ROWS)  read row address.
- rd_word  out  clog2(GRID_WORDS)  read word address.
- rd_data  in  20  read data, valid exactly 1 cycle after rd_en.
- top_row, middle_row, bottom_row  out  22 each  window to the cell array.
- win_valid  out  1  window stable and valid.
- result  in  20  next-state word from the cell array, combinational from the window.
- wr_en  out  1  write strobe to the next-generation RAM.
- wr_row, wr_word  out  as rd_row/rd_word  write address.
- wr_data  out  20  equals result.
- wr_ready  in  1  next-generation RAM accepts the write.

Function
REQ-004 SHALL map grid column 20*w+c to bit c of word w.
REQ-005 SHALL form each 22-bit window as {right word bit 0, centre word[19:0], left word bit 19}, so window bit i+1 is centre cell i.
REQ-006 SHALL hold a 3x3 word register array: columns left/centre/right, rows r-1/r/r+1.
REQ-007 SHALL implement the FSM as follows:
- IDLE -> PRIME on start.
- PRIME: load centre column with word 0; load left column with zero.
- FETCH: load right column with word w+1, or zero when w = GRID_WORDS-1.
- EMIT, then the exit condition below.
- DONE -> IDLE.
REQ-008 SHALL make each column load take exactly 4 cycles: rd_en on 3 consecutive cycles for rows r-1, r, r+1, then 1 trailing capture cycle.
REQ-009 SHALL, for a row outside 0..GRID_ROWS-1, keep rd_en low in that slot and load zero.
REQ-010 SHALL, in EMIT, assert win_valid and assert wr_en = wr_ready.
REQ-011 SHALL set wr_row = r and wr_word = w.
REQ-012 SHALL, on wr_en, shift columns left (left<=centre, centre<=right) and increment w.
REQ-013 SHALL, after the write of word GRID_WORDS-1, go to PRIME with r+1, or to DONE if r = GRID_ROWS-1.
REQ-014 SHALL, while wr_ready is low in EMIT, hold the window, addresses and win_valid unchanged.
REQ-015 SHALL achieve throughput of 5 cycles per word with wr_ready high, plus 4 PRIME cycles per row.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL never issue two reads in the same cycle.
REQ-018 SHALL never read or write an out-of-range address.

Reset
REQ-019 SHALL, on reset_n low, immediately go to IDLE and clear all registers and outputs to 0, including mid-pass.
REQ-020 SHALL discard a partially completed pass after reset; the next start restarts at row 0, word 0.

Configuration
REQ-021 SHALL, with CONWAY_TORUS_EN defined, wrap row -1 to GRID_ROWS-1 and row GRID_ROWS to 0.
REQ-022 SHALL, with CONWAY_TORUS_EN defined, make PRIME also fetch word GRID_WORDS-1 into the left column (8 cycles).
REQ-023 SHALL, with CONWAY_TORUS_EN defined, make FETCH at w = GRID_WORDS-1 load word 0.
REQ-024 SHALL, with CONWAY_TORUS_EN undefined, treat out-of-grid cells as dead (zero).

Structure
REQ-025 SHALL take WORD_LEN=20, WIN_LEN=22 and the FSM state enum from package conway_pkg.
REQ-026 SHALL place the 4-cycle three-row read sequencer in sub-module conway_col_fetch, instantiated once.

Verification
Scenarios use GRID_ROWS=4 and GRID_WORDS=2.
REQ-027 Reset: reset_n=0 -> all outputs 0 and state IDLE; after release, no rd_en until start.
REQ-028 Blinker across words:
- Stimulus: row 1, columns 19, 20, 21 live.
- Required: exactly 8 writes.
- Rows 0-2: word0=0x00000, word1=0x00001.
- Row 3: all zero.
- done pulses once.
REQ-029 Corner block (dead edges):
- Stimulus: cells (0,0), (0,1), (1,0), (1,1) live.
- Required: the same block is written back.
- No rd_en with row outside 0..3.
- Row-0 windows have top_row=0.
REQ-030 Back-pressure: wr_ready low for 10 cycles in EMIT -> window, addresses and win_valid held constant, no wr_en; the write completes on the cycle wr_ready rises.
REQ-031 Torus (CONWAY_TORUS_EN):
- Stimulus: row 0, columns 39, 0, 1 live.
- Required: word0 bit 0 set in rows 3, 0, 1.
- All other bits zero.
REQ-032 Reset and restart:
- reset_n pulsed low mid-row 2 -> outputs 0 at once.
- start while busy -> no effect.
- A fresh start -> full 8-write pass from (0,0).
